// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: DLX ID/EX boundary register with operand forwarding,
// load-use bubble insertion, ID-level jump target and a stall-cycle counter.
// Ports: clk/reset_n (sync, active-low); id_* decoded instruction and RF data;
// flush_ex, ex_ready from EX; ex_result, mem_*, wb_* forwarding sources;
// stall_id, jump_id/jump_target to IF/ID; ex_* registered bundle; stall_cnt.
module id_ex_hazard_stage #(
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_s1,
    input  logic [XLEN-1:0]   id_s2,
    input  logic              id_jump,
    input  logic              id_jreg,
    input  logic              flush_ex,
    input  logic              ex_ready,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_load,
    input  logic              mem_ready,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_id,
    output logic              jump_id,
    output logic [XLEN-1:0]   jump_target,
    output logic              ex_valid,
    output logic              ex_load,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_s1,
    output logic [XLEN-1:0]   ex_s2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [1:0][REG_W-1:0] rs;
    logic [1:0][XLEN-1:0]  rf;
    logic [1:0][XLEN-1:0]  fwd;
    logic [1:0]            src_use;
    logic [1:0]            ex_hit;
    logic [1:0]            mem_hit;
    logic [1:0]            wb_hit;
    logic [1:0]            haz_src;
    logic                  hazard;
    logic                  cnt_inc;

    assign rs      = {id_rs2, id_rs1};
    assign rf      = {id_s2, id_s1};
    assign src_use = {id_use2, id_use1};

    // A zero source index can never hit, so rd = 0 never forwards or stalls.
    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        haz_src = '0;
        fwd     = '0;
        for (int i = 0; i < 2; i++) begin
            ex_hit[i]  = ex_valid && (ex_rd == rs[i]) && (rs[i] != '0);
            mem_hit[i] = mem_valid && (mem_rd == rs[i]) && (rs[i] != '0);
            wb_hit[i]  = wb_valid && (wb_rd == rs[i]) && (rs[i] != '0);
            haz_src[i] = src_use[i]
                       && ((ex_hit[i] && ex_load)
                       ||  (mem_hit[i] && mem_load && !mem_ready));
            if (rs[i] == '0)
                fwd[i] = '0;
            else if (ex_hit[i] && !ex_load)
                fwd[i] = ex_result;
            else if (mem_hit[i] && (!mem_load || mem_ready))
                fwd[i] = mem_data;
            else if (wb_hit[i])
                fwd[i] = wb_data;
            else
                fwd[i] = rf[i];
        end
    end

    assign hazard   = id_valid && (|haz_src);
    assign stall_id = id_valid && !flush_ex && (hazard || !ex_ready);

    // Back-pressure stalls are not counted, even when a hazard coincides.
    assign cnt_inc  = hazard && !flush_ex && ex_ready;

    assign jump_id     = id_jump && id_valid && !stall_id && !flush_ex;
    assign jump_target = id_jreg ? fwd[0] : id_pc + id_imm;

    always_ff @(posedge clk) begin
        if (!reset_n || flush_ex) begin
            ex_valid <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_s1    <= '0;
            ex_s2    <= '0;
        end else if (!ex_ready) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_load  <= id_load;
            ex_rd    <= id_rd;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_ctrl  <= id_ctrl;
            ex_pc    <= id_pc;
            ex_imm   <= id_imm;
            ex_s1    <= fwd[0];
            ex_s2    <= fwd[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (cnt_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: scenario tasks for the ID/EX hazard stage.
// Expected EX bundles are queued when driven and popped after each edge.
module tb_id_ex_hazard_stage;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid;
    logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
    logic              id_use1, id_use2, id_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   id_pc, id_imm, id_s1, id_s2;
    logic              id_jump, id_jreg;
    logic              flush_ex, ex_ready;
    logic [XLEN-1:0]   ex_result;
    logic              mem_valid, mem_load, mem_ready;
    logic [REG_W-1:0]  mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              stall_id, jump_id;
    logic [XLEN-1:0]   jump_target;
    logic              ex_valid, ex_load;
    logic [REG_W-1:0]  ex_rd, ex_rs1, ex_rs2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_s1, ex_s2;
    logic [CW-1:0]     stall_cnt;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(
        .XLEN(XLEN), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
        .id_load(id_load), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_imm(id_imm), .id_s1(id_s1), .id_s2(id_s2),
        .id_jump(id_jump), .id_jreg(id_jreg),
        .flush_ex(flush_ex), .ex_ready(ex_ready), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_load(mem_load),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_id(stall_id), .jump_id(jump_id),
        .jump_target(jump_target),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_s1(ex_s1), .ex_s2(ex_s2),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] c0;

    task automatic idle();
        reset_n   = 1'b1;
        id_valid  = 1'b0;
        id_rs1    = '0;
        id_rs2    = '0;
        id_rd     = '0;
        id_use1   = 1'b0;
        id_use2   = 1'b0;
        id_load   = 1'b0;
        id_ctrl   = '0;
        id_pc     = '0;
        id_imm    = '0;
        id_s1     = '0;
        id_s2     = '0;
        id_jump   = 1'b0;
        id_jreg   = 1'b0;
        flush_ex  = 1'b0;
        ex_ready  = 1'b1;
        ex_result = '0;
        mem_valid = 1'b0;
        mem_load  = 1'b0;
        mem_ready = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1,
                         input logic u2, input logic ld,
                         input logic [31:0] s1, input logic [31:0] s2);
        id_valid = 1'b1;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_use1  = u1;
        id_use2  = u2;
        id_load  = ld;
        id_s1    = s1;
        id_s2    = s2;
        id_ctrl  = 8'h5a;
        id_pc    = 32'h100;
        id_imm   = 32'h4;
    endtask

    task automatic push(input logic v, input logic [4:0] rd,
                        input logic [31:0] s1, input logic [31:0] s2);
        exp_t x;
        x.v  = v;
        x.rd = rd;
        x.s1 = s1;
        x.s2 = s2;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h1, 32'h2);
        step();
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_s1 !== 32'd0
            || ex_pc !== 32'd0 || ex_ctrl !== 8'd0) begin
            bad++;
            $display("FAIL reset_regs: v=%b rd=%0d s1=%h pc=%h ctrl=%h want 0",
                     ex_valid, ex_rd, ex_s1, ex_pc, ex_ctrl);
        end
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        idle();
        step();
    endtask

    task automatic test_ex_forward();
        idle();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'h1, 32'h2);
        push(1'b1, 5'd3, 32'h1, 32'h2);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL add_capture: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        issue(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 32'hdead, 32'h5);
        ex_result = 32'h11;
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++;
            $display("FAIL ex_fwd_stall: stall_id=%b want 0", stall_id);
        end
        push(1'b1, 5'd4, 32'h11, 32'h5);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL ex_fwd: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        idle();
        step();
    endtask

    task automatic test_load_use();
        idle();
        issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
        push(1'b1, 5'd3, 32'h8, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL lw_capture: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        c0 = stall_cnt;
        issue(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 32'hbad, 32'h21);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall_ex: stall_id=%b want 1", stall_id);
        end
        push(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd) begin
            bad++;
            $display("FAIL lu_bubble1: got v=%b rd=%0d want v=%b rd=%0d",
                     ex_valid, ex_rd, e.v, e.rd);
        end
        total++;
        if (stall_cnt !== c0 + 4'd1) begin
            bad++;
            $display("FAIL lu_cnt1: got %0d want %0d", stall_cnt, c0 + 4'd1);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd3;
        mem_load  = 1'b1;
        mem_ready = 1'b0;
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall_mem: stall_id=%b want 1", stall_id);
        end
        push(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd) begin
            bad++;
            $display("FAIL lu_bubble2: got v=%b rd=%0d want v=%b rd=%0d",
                     ex_valid, ex_rd, e.v, e.rd);
        end
        total++;
        if (stall_cnt !== c0 + 4'd2) begin
            bad++;
            $display("FAIL lu_cnt2: got %0d want %0d", stall_cnt, c0 + 4'd2);
        end
        mem_ready = 1'b1;
        mem_data  = 32'hcafe;
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++;
            $display("FAIL lu_release: stall_id=%b want 0", stall_id);
        end
        push(1'b1, 5'd4, 32'hcafe, 32'h21);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL lu_fwd_mem: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        idle();
        step();
    endtask

    task automatic test_priority();
        idle();
        issue(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        // pass 0: EX/MEM/WB all hold r3; 1: EX moved on; 2: WB only; 3: RF
        for (int p = 0; p < 4; p++) begin
            issue(5'd3, 5'd0, (p == 0) ? 5'd6 : 5'd2, 1'b1, 1'b1, 1'b0,
                  32'h55, 32'h77);
            ex_result = 32'h5;
            mem_valid = (p < 2);
            mem_rd    = 5'd3;
            mem_data  = 32'h6;
            wb_valid  = (p < 3);
            wb_rd     = 5'd3;
            wb_data   = 32'h7;
            case (p)
                0:       push(1'b1, 5'd6, 32'h5, 32'h0);
                1:       push(1'b1, 5'd2, 32'h6, 32'h0);
                2:       push(1'b1, 5'd2, 32'h7, 32'h0);
                default: push(1'b1, 5'd2, 32'h55, 32'h0);
            endcase
            step();
            e = sb.pop_front();
            total++;
            if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
                bad++;
                $display("FAIL prio_%0d: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                         p, ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
            end
        end
        idle();
        issue(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        step();
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66);
        ex_result = 32'h9;
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++;
            $display("FAIL r0_no_hazard: stall_id=%b want 0", stall_id);
        end
        push(1'b1, 5'd4, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL r0_fwd: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        idle();
        issue(5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h5, 32'h0);
        step();
        c0 = stall_cnt;
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h9, 32'h0);
        flush_ex = 1'b1;
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: stall_id=%b want 0", stall_id);
        end
        push(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd) begin
            bad++;
            $display("FAIL flush_kill: got v=%b rd=%0d want v=%b rd=%0d",
                     ex_valid, ex_rd, e.v, e.rd);
        end
        total++;
        if (stall_cnt !== c0) begin
            bad++;
            $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, c0);
        end
        idle();
        step();
    endtask

    task automatic test_back_pressure();
        idle();
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'h10, 32'h20);
        step();
        c0 = stall_cnt;
        issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 32'h30, 32'h40);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (stall_id !== 1'b1) begin
                bad++;
                $display("FAIL bp_stall_%0d: stall_id=%b want 1", i, stall_id);
            end
            push(1'b1, 5'd5, 32'h10, 32'h20);
            step();
            e = sb.pop_front();
            total++;
            if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))
                || stall_cnt !== c0) begin
                bad++;
                $display("FAIL bp_hold_%0d: got v=%b rd=%0d s1=%h s2=%h cnt=%0d want v=%b rd=%0d s1=%h s2=%h cnt=%0d",
                         i, ex_valid, ex_rd, ex_s1, ex_s2, stall_cnt,
                         e.v, e.rd, e.s1, e.s2, c0);
            end
        end
        ex_ready = 1'b1;
        push(1'b1, 5'd6, 32'h30, 32'h40);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL bp_release: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        issue(5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0);
        step();
        c0 = stall_cnt;
        issue(5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0);
        ex_ready = 1'b0;
        push(1'b1, 5'd3, 32'h7, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))
            || stall_cnt !== c0) begin
            bad++;
            $display("FAIL bph_hold: got v=%b rd=%0d s1=%h cnt=%0d want v=%b rd=%0d s1=%h cnt=%0d",
                     ex_valid, ex_rd, ex_s1, stall_cnt, e.v, e.rd, e.s1, c0);
        end
        ex_ready = 1'b1;
        push(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || stall_cnt !== c0 + 4'd1) begin
            bad++;
            $display("FAIL bph_bubble: got v=%b rd=%0d cnt=%0d want v=%b rd=%0d cnt=%0d",
                     ex_valid, ex_rd, stall_cnt, e.v, e.rd, c0 + 4'd1);
        end
        idle();
        step();
    endtask

    task automatic test_jump();
        idle();
        step();
        issue(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h123, 32'h0);
        id_jump   = 1'b1;
        id_jreg   = 1'b1;
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'h400;
        #1;
        total++;
        if (jump_id !== 1'b1 || jump_target !== 32'h400) begin
            bad++;
            $display("FAIL jr_mem: jump=%b target=%h want 1 00000400",
                     jump_id, jump_target);
        end
        push(1'b1, 5'd0, 32'h400, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd || (e.v && (ex_s1 !== e.s1 || ex_s2 !== e.s2))) begin
            bad++;
            $display("FAIL jr_capture: got v=%b rd=%0d s1=%h s2=%h want v=%b rd=%0d s1=%h s2=%h",
                     ex_valid, ex_rd, ex_s1, ex_s2, e.v, e.rd, e.s1, e.s2);
        end
        id_jreg   = 1'b0;
        mem_valid = 1'b0;
        id_pc     = 32'hfffffffc;
        id_imm    = 32'h8;
        #1;
        total++;
        if (jump_id !== 1'b1 || jump_target !== 32'h4) begin
            bad++;
            $display("FAIL jpc_wrap: jump=%b target=%h want 1 00000004",
                     jump_id, jump_target);
        end
        ex_ready = 1'b0;
        #1;
        total++;
        if (jump_id !== 1'b0) begin
            bad++;
            $display("FAIL j_backpressure: jump=%b want 0", jump_id);
        end
        ex_ready = 1'b1;
        flush_ex = 1'b1;
        #1;
        total++;
        if (jump_id !== 1'b0) begin
            bad++;
            $display("FAIL j_flush: jump=%b want 0", jump_id);
        end
        idle();
        step();
    endtask

    task automatic test_saturation();
        idle();
        issue(5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_valid = 1'b1;
        mem_rd    = 5'd3;
        mem_load  = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            step();
        total++;
        if (stall_cnt !== 4'hf || stall_id !== 1'b1) begin
            bad++;
            $display("FAIL sat_cnt: cnt=%0d stall=%b want 15 1",
                     stall_cnt, stall_id);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        issue(5'd1, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset: v=%b rd=%0d cnt=%0d want 0 0 0",
                     ex_valid, ex_rd, stall_cnt);
        end
        idle();
        push(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        total++;
        if (ex_valid !== e.v || ex_rd !== e.rd) begin
            bad++;
            $display("FAIL post_reset: got v=%b rd=%0d want v=%b rd=%0d",
                     ex_valid, ex_rd, e.v, e.rd);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority();
        test_flush();
        test_back_pressure();
        test_jump();
        test_saturation();
        test_reset_mid_stall();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

Parametrised ID/EX boundary stage of the DLX pipeline. It takes the decoded instruction and the register-file operands from ID, resolves operand forwarding from the EX, MEM and WB stages, and detects load-use hazards, inserting a bubble when one occurs. It computes the ID-level jump target, handles the EX flush and downstream back-pressure, and registers the instruction into EX with a valid bit. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_W, 5, register index width
- CTRL_W, 8, width of the opaque decoded control bundle passed to EX
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  source indices
- id_use1, id_use2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  REG_W  destination index (0 = no write)
- id_load  in  1  instruction is a load
- id_ctrl  in  CTRL_W  decoded control bundle
- id_pc, id_imm  in  XLEN  PC of the ID instruction; sign-extended immediate
- id_s1, id_s2  in  XLEN  register-file read data
- id_jump, id_jreg  in  1  ID-level jump; target register-indirect (1) or PC-relative (0)
- flush_ex  in  1  taken branch resolved in EX; kill the ID instruction
- ex_ready  in  1  EX accepts a new instruction this cycle
- ex_result  in  XLEN  ALU result of the instruction currently in EX
- mem_valid, mem_load, mem_ready  in  1  MEM-stage instruction valid / is load / load data available
- mem_rd  in  REG_W, mem_data  in  XLEN  MEM destination and result (load data when mem_ready)
- wb_valid  in  1, wb_rd  in  REG_W, wb_data  in  XLEN  writeback
- stall_id  out  1  hold IF and ID this cycle
- jump_id  out  1, jump_target  out  XLEN  ID-level redirect
- ex_valid, ex_load  out  1
- ex_rd, ex_rs1, ex_rs2  out  REG_W
- ex_ctrl  out  CTRL_W
- ex_pc, ex_imm, ex_s1, ex_s2  out  XLEN
- stall_cnt  out  CNT_W  cycles spent in hazard stall

## Operation
- Register 0 is hardwired to zero.
  - rd = 0 never matches a source, never forwards and never raises a hazard.
  - A source index of 0 yields the value 0 regardless of id_s*.
- Forward mux per source, priority EX > MEM > WB > id_s*:
  - EX hit: ex_valid, ex_rd = rs, ex_load = 0 → ex_result.
  - MEM hit: mem_valid, mem_rd = rs, and (!mem_load or mem_ready) → mem_data.
  - WB hit: wb_valid, wb_rd = rs → wb_data.
- Hazard condition, evaluated only for sources with id_use set, and only when id_valid:
  - EX hit with ex_load = 1, or
  - MEM hit with mem_load = 1 and mem_ready = 0.
- stall_id = id_valid & !flush_ex & (hazard | !ex_ready).
- Register update per cycle, in priority order:
  - !reset_n: all outputs cleared.
  - flush_ex: ex_valid <= 0; other ex_* fields are don't-care but are cleared.
  - !ex_ready: the ID/EX register holds all fields.
  - hazard: bubble, ex_valid <= 0 and ex_rd <= 0.
  - Otherwise: capture id_* and the forwarded operands; ex_valid <= id_valid.
- Jump:
  - jump_id = id_jump & id_valid & !stall_id & !flush_ex.
  - jump_target = id_jreg ? forwarded s1 : id_pc + id_imm, computed modulo 2^XLEN.
- stall_cnt increments on every cycle with stall_id = 1 caused by a hazard (not back-pressure). It saturates at all-ones.

## Timing
- Reset value of every registered output is 0. jump_id and stall_id are combinational and may be X during reset.
- Latency: ID to EX is 1 cycle.
- Forwarding and hazard logic are combinational within the ID cycle. Operands are sampled into ex_s1/ex_s2 at the capture edge.
- Load-use:
  - Load in EX: 1 bubble.
  - Load then sits in MEM with mem_ready = 0: one further bubble per cycle until mem_ready = 1.
- Simultaneous flush_ex and hazard: flush wins, stall_id = 0, no counter increment.
- Simultaneous hazard and !ex_ready: hold the register, do not insert a bubble (the held instruction must not be lost). stall_cnt does not increment.
- A reset asserted mid-stall clears everything on the next edge; the stalled instruction is discarded.

## Test plan
- ADD r3,r1,r2 followed by SUB r4,r3,r5 with ex_result = 0x11 → ex_s1 = 0x11 next cycle, no stall.
- LW r3 (in EX) followed by ADD r4,r3,r1 → stall_id = 1 for 1 cycle, bubble, stall_cnt = 1. Then mem_ready = 1 with mem_data = 0xCAFE → ex_s1 = 0xCAFE.
- Same rd in EX (value 5), MEM (value 6) and WB (value 7), dependent read → ex_s1 = 5. With r0 as rd, value 9 in EX → ex_s1 = 0.
- Hazard and flush_ex in the same cycle → ex_valid = 0, stall_id = 0, stall_cnt unchanged.
- ex_ready = 0 for 3 cycles with an instruction in EX → ex_* stable, stall_id = 1, stall_cnt unchanged. Then ex_ready = 1 → ID instruction captured.
- Register-indirect jump (JR r7) with r7 forwarded from MEM = 0x400 → jump_id = 1, jump_target = 0x400. With id_pc = 0xFFFFFFFC and id_imm = 8 (PC-relative) → jump_target = 0x4.
